// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART rx (clk, rst, rec_en, dfv bit period-1, uart_rx async in) -> rx_data/rx_valid held until rx_ack, frame_err/overrun pulses
module uart_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rec_en,
  input  logic [15:0] dfv,
  input  logic        uart_rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ack,
  output logic        frame_err,
  output logic        overrun
);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] sync;
  logic        rxs;
  logic [15:0] cnt, cnt_n, half;
  logic [3:0]  bit_cnt, bit_n;
  logic [7:0]  sh, sh_n, data_n;
  logic        valid_n, ferr_n, ovr_n;
  assign rxs  = sync[SYNC_STAGES-1];
  assign half = dfv >> 1;
  always_ff @(posedge clk) begin
    sync <= rst ? '1 : {sync[SYNC_STAGES-2:0], uart_rx};
    if (rst || !rec_en) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_n;
      sh        <= sh_n;
      rx_data   <= data_n;
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
      overrun   <= ovr_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 16'd1;
    bit_n   = bit_cnt;
    sh_n    = sh;
    data_n  = rx_data;
    valid_n = rx_valid & ~rx_ack;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        state_n = rxs ? IDLE : START;
      end
      START: if (cnt == half) begin
        cnt_n   = '0;
        bit_n   = '0;
        state_n = rxs ? IDLE : DATA;
      end
      DATA: if (cnt == dfv) begin
        cnt_n   = '0;
        sh_n    = {rxs, sh[7:1]};
        bit_n   = bit_cnt + 4'd1;
        state_n = (bit_cnt == 4'd7) ? STOP : DATA;
      end
      STOP: if (cnt == dfv) begin
        cnt_n   = '0;
        state_n = rxs ? IDLE : BREAK;
        ferr_n  = ~rxs;
        if (rxs && (!rx_valid || rx_ack)) begin
          data_n  = sh;
          valid_n = 1'b1;
        end
        ovr_n = rxs & rx_valid & ~rx_ack;
      end
      BREAK: begin
        cnt_n   = '0;
        state_n = rxs ? IDLE : BREAK;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scoreboard bench for uart_receiver at dfv=15 (16 clocks/bit)
module tb_uart_receiver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rec_en = 1'b1;
  logic [15:0] dfv = 16'd15;
  logic        uart_rx = 1'b1;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ack = 1'b0;
  logic        frame_err;
  logic        overrun;
  int total = 0, bad = 0;
  int ferr_cnt = 0, ovr_cnt = 0, deliv = 0;
  logic [7:0] exp_q[$];
  uart_receiver dut (
    .clk(clk), .rst(rst), .rec_en(rec_en), .dfv(dfv), .uart_rx(uart_rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .frame_err(frame_err), .overrun(overrun)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic bit_out(input logic v);
    uart_rx = v;
    tick(16);
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    for (int i = 0; i < 8; i++) bit_out(b[i]);
    bit_out(stop);
  endtask
  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick(1);
    rx_ack = 1'b0;
  endtask
  task automatic wait_ack();
    int n = 0;
    while (!rx_valid && n < 400) begin
      tick(1);
      n++;
    end
    if (n >= 400) begin
      total++;
      bad++;
      $display("FAIL wait_valid timeout got=%0d want<400", n);
    end
    ack_pulse();
  endtask
  task automatic monitor();
    logic pv = 1'b0, pa = 1'b0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (frame_err) ferr_cnt++;
      if (overrun) ovr_cnt++;
      if (rx_valid && (!pv || pa)) begin
        deliv++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte got=%0h want=none", rx_data);
        end else begin
          e = exp_q.pop_front();
          chk("sb_rx_data", int'(rx_data), int'(e));
        end
      end
      pv = rx_valid;
      pa = rx_ack;
    end
  endtask
  task automatic stimulus();
    int n, d0;
    tick(3);
    chk("rst_rx_data", int'(rx_data), 0);
    chk("rst_rx_valid", int'(rx_valid), 0);
    chk("rst_frame_err", int'(frame_err), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst = 1'b0;
    tick(5);
    exp_q.push_back(8'h55);
    fork
      send(8'h55, 1'b1);
      begin
        n = 0;
        while (!rx_valid && n < 300) begin
          tick(1);
          n++;
        end
        chk("latency", n, 155);
      end
    join
    chk("data_55", int'(rx_data), 8'h55);
    chk("ferr_none", ferr_cnt, 0);
    chk("ovr_none", ovr_cnt, 0);
    ack_pulse();
    tick(5);
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    fork
      begin
        send(8'hA3, 1'b1);
        send(8'h0F, 1'b1);
      end
      begin
        wait_ack();
        wait_ack();
      end
    join
    tick(5);
    chk("b2b_deliv", deliv, 3);
    chk("b2b_ferr", ferr_cnt, 0);
    chk("b2b_ovr", ovr_cnt, 0);
    send(8'h3C, 1'b0);
    tick(40);
    uart_rx = 1'b1;
    tick(20);
    chk("ferr_once", ferr_cnt, 1);
    chk("ferr_no_valid", int'(rx_valid), 0);
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1);
    tick(3);
    chk("after_break_data", int'(rx_data), 8'h81);
    chk("after_break_ferr", ferr_cnt, 1);
    ack_pulse();
    tick(5);
    d0 = deliv;
    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    tick(200);
    chk("glitch_deliv", deliv, d0);
    chk("glitch_valid", int'(rx_valid), 0);
    chk("glitch_ferr", ferr_cnt, 1);
    exp_q.push_back(8'hFF);
    send(8'hFF, 1'b1);
    tick(3);
    chk("data_ff", int'(rx_data), 8'hFF);
    ack_pulse();
    tick(5);
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1);
    tick(3);
    send(8'h22, 1'b1);
    tick(3);
    chk("ovr_data_kept", int'(rx_data), 8'h11);
    chk("ovr_valid", int'(rx_valid), 1);
    chk("ovr_once", ovr_cnt, 1);
    exp_q.push_back(8'h22);
    fork
      send(8'h22, 1'b1);
      begin
        tick(154);
        ack_pulse();
      end
    join
    tick(3);
    chk("ack_cmp_data", int'(rx_data), 8'h22);
    chk("ack_cmp_valid", int'(rx_valid), 1);
    chk("ack_cmp_ovr", ovr_cnt, 1);
    ack_pulse();
    tick(5);
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1);
    tick(3);
    chk("pre_rst_data", int'(rx_data), 8'h11);
    bit_out(1'b0);
    bit_out(1'b1);
    bit_out(1'b0);
    bit_out(1'b1);
    rst = 1'b1;
    uart_rx = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_data", int'(rx_data), 0);
    chk("mid_rst_valid", int'(rx_valid), 0);
    rec_en = 1'b0;
    tick(5);
    rec_en = 1'b1;
    tick(200);
    chk("mid_rst_ferr", ferr_cnt, 1);
    chk("mid_rst_valid2", int'(rx_valid), 0);
    exp_q.push_back(8'hC6);
    send(8'hC6, 1'b1);
    tick(3);
    chk("data_c6", int'(rx_data), 8'hC6);
    chk("queue_drained", exp_q.size(), 0);
    chk("deliv_total", deliv, 9);
  endtask
  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Receive-side stage that consumes the serial line driven by the team's UART transmitter (8N1, LSB first, idle high).
- Synchronises the line, detects the start bit and samples each bit at mid-period, using the same divider value `dfv`, so the bit period is dfv+1 clocks.
- Delivers each received byte to the controller through a valid/ack holding register.
- Reports framing and overrun errors.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in the uart_rx synchroniser (minimum 2).

Ports:
- clk        input   1   system clock
- rst        input   1   synchronous reset, active-high
- rec_en     input   1   receiver enable
- dfv        input   16  divide frequency value; bit period = dfv+1 clocks
- uart_rx    input   1   UART rx wire (asynchronous)
- rx_data    output  8   last received byte
- rx_valid   output  1   rx_data holds an unread byte
- rx_ack     input   1   controller consumed rx_data
- frame_err  output  1   one-cycle pulse: stop bit sampled low
- overrun    output  1   one-cycle pulse: byte lost because rx_valid was still set

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; counter, bit_cnt and shift register are cleared.
  - rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0.
  - Synchroniser flops reset to 1.
- rec_en=0: same clearing as reset, including rx_valid=0. The synchroniser keeps running.
- Synchronised line rxs: uart_rx delayed by SYNC_STAGES clocks. All decisions below use rxs only.
- Counter is 16 bit; half = dfv>>1.
- States IDLE, START, DATA, STOP, BREAK:
  - IDLE: counter=0. When rxs=0, go to START. Call this cycle t0.
  - START: counter increments each clock.
    - At counter==half: if rxs=0, go to DATA with counter=0 and bit_cnt=0.
    - If rxs=1 at that point (glitch), go back to IDLE. No outputs change.
  - DATA: counter increments each clock.
    - At counter==dfv: shift rxs into bit[bit_cnt] (LSB first), set counter=0, bit_cnt+1.
    - After the 8th sample (bit_cnt reaches 8), go to STOP.
  - STOP: at counter==dfv, sample rxs.
    - rxs=1: byte complete, go to IDLE.
    - rxs=0: assert frame_err for one cycle, discard the byte, go to BREAK.
  - BREAK: wait until rxs=1, then go to IDLE. No new start is detected while in BREAK.
- Sample instants: t0 + half + k*(dfv+1) for k=1..8 (data bits) and k=9 (stop bit).
- Leaving STOP at mid-stop-bit allows back-to-back frames with no idle gap.
- Completion cycle (valid stop bit):
  - rx_valid=0, or rx_valid=1 with rx_ack=1: rx_data takes the new byte and rx_valid=1 on the next clock.
  - rx_valid=1 with rx_ack=0: the new byte is discarded, rx_data is unchanged, overrun pulses for one cycle.
- rx_ack with rx_valid=1 and no completion: rx_valid=0 next clock. rx_ack with rx_valid=0 is ignored.
- Latency: rx_valid rises one clock after the stop-bit sample.
- dfv must not change mid-frame; a change takes effect at the next start bit. With dfv=0 the block is not required to operate.
- Reset or rec_en deassertion mid-frame: the frame is abandoned immediately with no error pulse. If the line is still low when rec_en returns to 1, the remaining low bits are treated as a new start bit.

Test Plan:
- dfv=15, one frame 0x55 at 16 clocks/bit, rx_ack held 0 -> rx_valid rises 1 clock after the stop sample (about 9.5 bit periods after the falling edge), rx_data=8'h55, frame_err=0, overrun=0.
- dfv=15, back-to-back frames 0xA3 then 0x0F with no idle gap, rx_ack pulsed after each rx_valid -> two rx_valid events with data 8'hA3 then 8'h0F, no errors.
- dfv=15, frame 0x3C with the stop bit driven low, line high 40 clocks later -> frame_err single pulse, rx_valid stays 0, state BREAK until the line goes high, then a following 0x81 frame is received correctly.
- dfv=15, low glitch of 4 clocks on an idle line -> return to IDLE at the half check, no rx_valid, no errors. A subsequent valid 0xFF frame is received as 8'hFF.
- dfv=15, frames 0x11 then 0x22 with rx_ack never asserted -> rx_data stays 8'h11, overrun pulses once at the second stop sample. With rx_ack asserted exactly on the completion cycle instead, rx_data becomes 8'h22, rx_valid stays 1, no overrun.
- rx_data valid with 0x11, then mid-frame (after 3 data bits) drive rst=1 for 1 clock, then rec_en=0 for 5 clocks -> outputs at reset values, no frame_err, the partial frame discarded. A following 0xC6 frame is received correctly.
